// File: rtl/branch_predictor.sv
// Next-PC generator: direct-mapped BTB with 2-bit saturating counters and two
// saturating event counters. Optional gshare indexing under BP_GSHARE_EN.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int GHR_W   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] next_pc,
  output logic        pred_taken,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  function automatic logic [31:0] sat_inc32(input logic [31:0] x);
    return (x == 32'hFFFF_FFFF) ? x : x + 32'd1;
  endfunction

  function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
    if (taken) return (c == 2'b11) ? c : c + 2'd1;
    else       return (c == 2'b00) ? c : c - 2'd1;
  endfunction

  logic              valid_q  [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [31:0]       target_q [ENTRIES];
  logic [31:0]       branch_cnt_q, branch_cnt_d;
  logic [31:0]       mispredict_cnt_q, mispredict_cnt_d;
  logic [IDX_W-1:0]  hist;

`ifdef BP_GSHARE_EN
  logic [GHR_W-1:0]  ghr_q, ghr_d;

  // Shift form avoids an empty slice when GHR_W is 1.
  assign ghr_d = upd_valid ? ((ghr_q << 1) | GHR_W'(upd_taken)) : ghr_q;
  assign hist  = IDX_W'(ghr_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ghr_q <= '0;
    else        ghr_q <= ghr_d;
  end
`else
  logic [GHR_W-1:0]  unused_ghr;
  assign unused_ghr = '0;
  assign hist       = '0;
`endif

  logic              unused_pc_lsb;
  assign unused_pc_lsb = ^{current_pc[1:0], upd_pc[1:0]};

  // Lookup
  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit, lk_taken;

  assign lk_idx   = current_pc[IDX_W+1:2] ^ hist;
  assign lk_tag   = current_pc[31:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && ctr_q[lk_idx][1];

  always_comb begin
    next_pc    = current_pc + 32'd4;
    pred_taken = 1'b0;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (stall) begin
      next_pc = current_pc;
    end else if (lk_taken) begin
      next_pc    = target_q[lk_idx];
      pred_taken = 1'b1;
    end
  end

  // Training
  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic [1:0]        up_ctr_d;

  assign up_idx   = upd_pc[IDX_W+1:2] ^ hist;
  assign up_tag   = upd_pc[31:IDX_W+2];
  assign up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr_d = up_hit ? ctr_step(ctr_q[up_idx], upd_taken) : 2'b10;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (upd_valid && (up_hit || upd_taken)) begin
      valid_q[up_idx] <= 1'b1;
      ctr_q[up_idx]   <= up_ctr_d;
    end
  end

  // Tag/target are only meaningful behind valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      tag_q[up_idx]    <= up_tag;
      target_q[up_idx] <= upd_target;
    end
  end

  assign branch_cnt_d     = upd_valid      ? sat_inc32(branch_cnt_q)     : branch_cnt_q;
  assign mispredict_cnt_d = redirect_valid ? sat_inc32(mispredict_cnt_q) : mispredict_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_cnt_q     <= '0;
      mispredict_cnt_q <= '0;
    end else begin
      branch_cnt_q     <= branch_cnt_d;
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

  assign branch_cnt     = branch_cnt_q;
  assign mispredict_cnt = mispredict_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor; gshare sequence selected by BP_GSHARE_EN.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] current_pc;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] next_pc;
  logic        pred_taken;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;

  int n_cmp = 0;
  int n_err = 0;

  branch_predictor #(.ENTRIES(16), .GHR_W(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .current_pc     (current_pc),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .next_pc        (next_pc),
    .pred_taken     (pred_taken),
    .branch_cnt     (branch_cnt),
    .mispredict_cnt (mispredict_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One training cycle; inputs applied after posedge, sampled at the next one.
  task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    upd_valid  = 1'b1;
    upd_pc     = pc;
    upd_taken  = tk;
    upd_target = tgt;
    @(posedge clk); #1;
    upd_valid  = 1'b0;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic [31:0] exp_pc, input logic exp_tk);
    current_pc = pc;
    @(negedge clk);
    check({tag, ".next_pc"}, next_pc, exp_pc);
    check({tag, ".pred"}, 32'(pred_taken), 32'(exp_tk));
  endtask

  initial begin
    reset          = 1'b0;
    current_pc     = 32'h100;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    upd_valid      = 1'b0;
    upd_pc         = '0;
    upd_taken      = 1'b0;
    upd_target     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("in_reset.next_pc", next_pc, 32'h104);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    look("reset_state", 32'h100, 32'h104, 1'b0);
    check("reset.branch_cnt", branch_cnt, 32'd0);
    check("reset.mispredict_cnt", mispredict_cnt, 32'd0);

`ifdef BP_GSHARE_EN
    @(posedge clk); #1;
    train(32'h100, 1'b1, 32'h200);
    look("gs_shifted_miss", 32'h100, 32'h104, 1'b0);
    look("gs_alias_hit", 32'h104, 32'h200, 1'b1);
    check("gs.branch_cnt", branch_cnt, 32'd1);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("gs_async_rst.next_pc", next_pc, 32'h108);
    check("gs_async_rst.pred", 32'(pred_taken), 32'd0);
    check("gs_async_rst.branch_cnt", branch_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    look("gs_after_rst", 32'h100, 32'h104, 1'b0);
`else
    @(posedge clk); #1;
    train(32'h100, 1'b1, 32'h200);
    look("alloc", 32'h100, 32'h200, 1'b1);
    check("alloc.branch_cnt", branch_cnt, 32'd1);
    look("alias", 32'h140, 32'h144, 1'b0);
    stall = 1'b1;
    look("stall_hold", 32'h100, 32'h100, 1'b0);
    stall = 1'b0;

    @(posedge clk); #1;
    current_pc     = 32'h100;
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    #1;
    check("redirect.next_pc", next_pc, 32'h300);
    check("redirect.pred", 32'(pred_taken), 32'd0);
    @(posedge clk); #1;
    redirect_valid = 1'b0;
    stall          = 1'b0;
    check("redirect.mispredict_cnt", mispredict_cnt, 32'd1);

    for (int i = 0; i < 3; i++) train(32'h100, 1'b1, 32'h200);
    train(32'h100, 1'b0, 32'h0);
    look("ctr3_nt_once", 32'h100, 32'h200, 1'b1);
    train(32'h100, 1'b0, 32'h0);
    look("ctr1_nt_twice", 32'h100, 32'h104, 1'b0);
    check("burst.branch_cnt", branch_cnt, 32'd6);

    train(32'h100, 1'b1, 32'h280);
    look("retarget", 32'h100, 32'h280, 1'b1);
    train(32'h180, 1'b0, 32'h0);
    look("nt_miss_keeps", 32'h100, 32'h280, 1'b1);
    look("nt_miss_noalloc", 32'h180, 32'h184, 1'b0);
    look("wrap", 32'hFFFF_FFFC, 32'h0, 1'b0);

    current_pc = 32'h108;
    upd_valid  = 1'b1;
    upd_pc     = 32'h108;
    upd_taken  = 1'b1;
    upd_target = 32'h400;
    #1;
    check("no_bypass.next_pc", next_pc, 32'h10C);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    look("trained_next", 32'h108, 32'h400, 1'b1);
    check("final.branch_cnt", branch_cnt, 32'd9);

    train(32'h100, 1'b1, 32'h280);
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    check("async_rst.next_pc", next_pc, 32'h10C);
    check("async_rst.pred", 32'(pred_taken), 32'd0);
    check("async_rst.branch_cnt", branch_cnt, 32'd0);
    check("async_rst.mispredict_cnt", mispredict_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    look("after_rst", 32'h100, 32'h104, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Next-PC generator that sits directly upstream of the program counter register and drives its `next_pc` input every cycle. It is a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It combinationally selects among an EX-stage redirect, a stall hold, a predicted-taken target, or the sequential `current_pc + 4`. The table is trained by branch resolutions from EX, and the block keeps two saturating performance counters.

## Interface
Parameters:
- `ENTRIES`, 16: BTB entry count; power of two, ≥ 2. `IDX_W = log2(ENTRIES)`.
- `GHR_W`, 4: global history width; used only when `BP_GSHARE_EN` is defined; must satisfy 1 ≤ `GHR_W` ≤ `IDX_W`.

Ports:
- `clk`  in  1  Clock, rising edge.
- `reset`  in  1  Asynchronous, active-low reset.
- `current_pc`  in  32  PC of the instruction being fetched.
- `stall`  in  1  Hazard stall: hold the PC.
- `redirect_valid`  in  1  EX resolved a misprediction; highest priority.
- `redirect_pc`  in  32  Correct PC on a misprediction.
- `upd_valid`  in  1  A branch or jump resolved in EX this cycle.
- `upd_pc`  in  32  PC of the resolved branch.
- `upd_taken`  in  1  Resolved direction.
- `upd_target`  in  32  Resolved target.
- `next_pc`  out  32  Combinational next PC.
- `pred_taken`  out  1  Combinational; 1 when `next_pc` comes from the BTB.
- `branch_cnt`  out  32  Count of `upd_valid` cycles, registered.
- `mispredict_cnt`  out  32  Count of `redirect_valid` cycles, registered.

## Operation
- Each entry holds `valid`, `tag[31:IDX_W+2]`, `target[31:0]` and `ctr[1:0]`.
- Lookup index is `current_pc[IDX_W+1:2]`, XOR history when gshare is enabled. Tag is `current_pc[31:IDX_W+2]`.
- Hit: `valid` is set and the tag matches. Predict taken when the entry hits and `ctr[1]` = 1.
- `next_pc` priority:
  1. `redirect_valid` → `redirect_pc`
  2. `stall` → `current_pc`
  3. predicted taken → entry `target`
  4. otherwise → `current_pc + 4`, mod 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- `pred_taken` = 1 only in case 3. Redirect overrides stall.
- Update happens at the posedge when `upd_valid` = 1, on the entry at the index of `upd_pc`:
  - Tag hit: `ctr` increments if taken, decrements if not taken, saturating at 0 and 3. On taken, `target` ← `upd_target`.
  - Tag miss and taken: allocate. `valid` ← 1, `tag`, `target`, `ctr` ← 2'b10.
  - Tag miss and not taken: no change.
- Same-cycle lookup and update of the same index: lookup sees the pre-update entry; no bypass.
- `branch_cnt` increments on `upd_valid`; `mispredict_cnt` increments on `redirect_valid`. Both saturate at 0xFFFF_FFFF. `redirect_valid` and `upd_valid` in the same cycle increment both.
- Reset (`reset` = 0):
  - All `valid` bits ← 0, all `ctr` ← 2'b01.
  - Both counters and the history register ← 0.
  - While in reset, `next_pc` follows the priority rules against the empty table, so the output is never a BTB target.

## Timing
- Prediction latency is zero cycles: `next_pc` and `pred_taken` are purely combinational from the inputs and table state.
- Training latency is one cycle: an update at edge N affects lookups from cycle N+1.
- Counters are registered; a new value is visible the cycle after the event.
- Reset assertion clears state immediately, independent of `clk`. Deassertion is synchronised externally; the first update is accepted at the first rising edge with `reset` = 1.
- A reset in the middle of a training burst discards all learned entries; no partial write survives.

## Configuration
- `BP_GSHARE_EN` defined:
  - Adds a `GHR_W`-bit global history register.
  - On each `upd_valid`, `ghr` ← {`ghr[GHR_W-2:0]`, `upd_taken`}.
  - Lookup and update index = PC index bits XOR {0, `ghr`}.
  - The update uses the `ghr` value before that cycle's shift.
- `BP_GSHARE_EN` undefined: no history register; index is the PC bits only.

## Test plan
All scenarios use `ENTRIES` = 16 with `BP_GSHARE_EN` undefined, except scenario 6.

1. Reset, then `current_pc` = 0x100 → `next_pc` = 0x104, `pred_taken` = 0, `branch_cnt` = `mispredict_cnt` = 0.
2. One update: `upd_pc` = 0x100, taken, target 0x200. Next cycle, `current_pc` = 0x100 → `next_pc` = 0x200, `pred_taken` = 1, `branch_cnt` = 1.
3. Continue from 2:
   - Three more taken updates (`ctr` = 3), then one not-taken → still predicts 0x200.
   - A second not-taken (`ctr` = 1) → `next_pc` = 0x104.
4. Aliasing: after scenario 2, `current_pc` = 0x140 (same index 0, different tag) → `next_pc` = 0x144, `pred_taken` = 0.
5. `redirect_valid` = 1, `redirect_pc` = 0x300, `stall` = 1, BTB hit active → `next_pc` = 0x300, `pred_taken` = 0, `mispredict_cnt` increments by 1.
6. With `BP_GSHARE_EN`, `GHR_W` = 4:
   - Train pc 0x100 taken to 0x200 once, with the pre-shift `ghr` = 0.
   - Then `ghr` = 0001, and lookup of 0x100 uses index 1 → miss, `next_pc` = 0x104.
   - Assert `reset` asynchronously mid-cycle → all outputs return to reset behaviour before the next edge.
